pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the successor to the fixed M→W write-enable register. It carries `NUM_CH` payload channels of `DATA_W` bits each (instr, ALU result, DM data, RT, PC, HI/LO, …) between any two pipeline stages. Back-pressure replaces the raw stall/WE pin, and a stall-cycle counter supports performance debug.

---
 rtl/pipe_skid_stage_pkg.sv | 39 +++
 rtl/pipe_skid_stage_if.sv | 30 +++
 rtl/pipe_skid_stage_sat_counter.sv | 35 +++
 rtl/pipe_skid_stage.sv | 175 +++++++++++++++++
 tb/tb_pipe_skid_stage.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: stage state encoding, payload channel indices
// and the BUBBLE payload builder used by every pipeline stage register.
package pipe_skid_stage_pkg;

    localparam int unsigned MAX_PAYLOAD_W = 32'd512;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

    localparam int unsigned CH_INSTR = 32'd0;
    localparam int unsigned CH_ALU   = 32'd1;
    localparam int unsigned CH_DM    = 32'd2;
    localparam int unsigned CH_RT    = 32'd3;
    localparam int unsigned CH_PC    = 32'd4;
    localparam int unsigned CH_HILO  = 32'd5;

    // All channels zero except the PC channel, which carries reset_pc.
    function automatic logic [MAX_PAYLOAD_W-1:0] bubble_payload(
        input int unsigned data_w,
        input int unsigned num_ch,
        input int unsigned pc_ch,
        input logic [31:0] reset_pc
    );
        logic [MAX_PAYLOAD_W-1:0] b;
        b = '0;
        for (int unsigned i = 32'd0; i < MAX_PAYLOAD_W; i++) begin
            if ((i < data_w * num_ch) && ((i / data_w) == pc_ch) && ((i % data_w) < 32'd32)) begin
                b[i] = reset_pc[5'(i % data_w)];
            end else begin
                b[i] = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between an upstream producer, a pipe_skid_stage and its
// downstream consumer; master drives the stage, slave is the stage itself.
interface pipe_skid_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned PAYLOAD_W = DATA_W * NUM_CH;

    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_data;
    logic [1:0]           occupancy;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_cnt
    );

endinterface

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: increment when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_SKID_EN for the registered-ready two-entry skid variant.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_CH   = 6,
    parameter int unsigned PC_CH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_skid_stage_if.slave bus
);

    localparam int unsigned PAYLOAD_W = DATA_W * NUM_CH;
    localparam logic [PAYLOAD_W-1:0] BUBBLE =
        PAYLOAD_W'(bubble_payload(DATA_W, NUM_CH, PC_CH, RESET_PC));

    state_t               state_q;
    state_t               state_d;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] main_d;
    logic                 out_valid_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 drain_s;
    logic                 stall_en_s;
    logic [CNT_W-1:0]     stall_cnt_s;

    assign out_valid_s = (state_q != ST_EMPTY);
    assign accept_s    = bus.in_valid && in_ready_s;
    assign drain_s     = out_valid_s && bus.out_ready;
    assign stall_en_s  = out_valid_s && !bus.out_ready;

`ifdef PIPE_SKID_EN
    logic [PAYLOAD_W-1:0] skid_q;
    logic [PAYLOAD_W-1:0] skid_d;
    logic                 in_ready_q;
    logic                 in_ready_d;

    // Ready comes straight from a flop so it never depends on out_ready.
    assign in_ready_s = in_ready_q;

    // Next-state logic for the EMPTY/ONE/TWO occupancy machine.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_ready_d = in_ready_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        main_d = bus.in_data;
                    end else if (accept_s) begin
                        state_d = ST_TWO;
                        skid_d  = bus.in_data;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    // Skid entry and registered ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    // Without a skid entry the stage can only take data when main frees up.
    assign in_ready_s = !out_valid_s || bus.out_ready;

    // Next-state logic for the EMPTY/ONE single-register machine.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s) begin
                        main_d = bus.in_data;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            endcase
        end
    end
`endif

    // Occupancy state and the main output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (stall_en_s),
        .cnt_o (stall_cnt_s)
    );

    // State encoding doubles as the entry count.
    assign bus.occupancy = state_q;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = main_q;
    assign bus.in_ready  = in_ready_s;
    assign bus.stall_cnt = stall_cnt_s;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_CH   = 6;
    localparam int unsigned PC_CH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned W        = DATA_W * NUM_CH;
    localparam int          STALL_MAX = 15;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? 2 : 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_skid_stage_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    pipe_skid_stage #(
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .PC_CH    (PC_CH),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    int           mstall;
    bit           last_acc;
    bit           obs_drn;
    logic [23:0]  obs_word;

    typedef struct {
        bit          v;
        logic [23:0] word;
        bit          f;
        bit          exp_valid;
        logic [23:0] exp_word;
        int          exp_occ;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [W-1:0] bubble();
        logic [W-1:0] b;
        b = '0;
        b[PC_CH*DATA_W +: DATA_W] = RESET_PC;
        return b;
    endfunction

    function automatic logic [W-1:0] mk(input logic [23:0] word);
        logic [W-1:0] p;
        for (int k = 0; k < NUM_CH; k++) p[k*DATA_W +: DATA_W] = {8'(k), word};
        return p;
    endfunction

    function automatic logic [W-1:0] rnd_payload();
        logic [W-1:0] p;
        for (int k = 0; k < NUM_CH; k++) p[k*DATA_W +: DATA_W] = $urandom();
        return p;
    endfunction

    function automatic bit model_ready(input bit r);
        return SKID ? (mq.size() < CAP) : ((mq.size() == 0) || r);
    endfunction

    task automatic chk_bit(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b required %b at %0t", name, a, e, $time);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0d required %0d at %0t", name, a, e, $time);
        end
    endtask

    task automatic chk_pay(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, a, e, $time);
        end
    endtask

    task automatic check_model(input bit r);
        chk_bit("in_ready", bus.in_ready, model_ready(r));
        chk_bit("out_valid", bus.out_valid, mq.size() > 0);
        chk_int("occupancy", int'(bus.occupancy), mq.size());
        chk_pay("out_data", bus.out_data, (mq.size() > 0) ? mq[0] : bubble());
        chk_int("stall_cnt", int'(bus.stall_cnt), mstall);
    endtask

    // Drive one cycle of inputs, check against the model, advance both.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        bit acc;
        bit drn;
        logic [W-1:0] junk;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        #1;
        check_model(r);
        obs_drn  = bus.out_valid && bus.out_ready;
        obs_word = bus.out_data[23:0];
        acc = v && model_ready(r);
        drn = (mq.size() > 0) && r;
        last_acc = acc;
        if ((mq.size() > 0) && !r && (mstall < STALL_MAX)) mstall++;
        if (f) begin
            mq.delete();
        end else begin
            if (drn) junk = mq.pop_front();
            if (acc) mq.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        chk_int("rst_occupancy", int'(bus.occupancy), 0);
        chk_pay("rst_out_data", bus.out_data, bubble());
        chk_int("rst_stall_cnt", int'(bus.stall_cnt), 0);
        chk_bit("rst_in_ready", bus.in_ready, 1'b1);
        mq.delete();
        mstall = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int drains;
        logic [23:0] got[$];

        for (int i = 0; i < 8; i++)
            tbl[i] = '{v: 1'b1, word: 24'(i + 1), f: 1'b0,
                       exp_valid: (i > 0), exp_word: 24'(i), exp_occ: (i > 0) ? 1 : 0};
        tbl[8]  = '{v: 1'b0, word: 24'd0,  f: 1'b0, exp_valid: 1'b1, exp_word: 24'd8, exp_occ: 1};
        tbl[9]  = '{v: 1'b0, word: 24'd0,  f: 1'b0, exp_valid: 1'b0, exp_word: 24'd0, exp_occ: 0};
        tbl[10] = '{v: 1'b1, word: 24'd9,  f: 1'b0, exp_valid: 1'b0, exp_word: 24'd0, exp_occ: 0};
        tbl[11] = '{v: 1'b1, word: 24'd10, f: 1'b1, exp_valid: 1'b1, exp_word: 24'd9, exp_occ: 1};
        tbl[12] = '{v: 1'b0, word: 24'd0,  f: 1'b0, exp_valid: 1'b0, exp_word: 24'd0, exp_occ: 0};
        tbl[13] = '{v: 1'b0, word: 24'd0,  f: 1'b0, exp_valid: 1'b0, exp_word: 24'd0, exp_occ: 0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #2;
        do_reset();

        // Streaming with flush, from the vector table.
        for (int i = 0; i < 14; i++) begin
            chk_bit("tbl_valid", bus.out_valid, tbl[i].exp_valid);
            chk_int("tbl_occ", int'(bus.occupancy), tbl[i].exp_occ);
            chk_pay("tbl_data", bus.out_data, tbl[i].exp_valid ? mk(tbl[i].exp_word) : bubble());
            step(tbl[i].v, mk(tbl[i].word), 1'b1, tbl[i].f);
        end

        // Back-pressure: offer three words while downstream stalls.
        do_reset();
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            step(sent < 3, mk(24'(sent + 1)), 1'b0, 1'b0);
            if (last_acc) sent++;
        end
        chk_int("stall_accepted", sent, CAP);
        chk_int("stall_occupancy", int'(bus.occupancy), CAP);
        chk_bit("stall_in_ready", bus.in_ready, 1'b0);
        chk_int("stall_cnt_held", int'(bus.stall_cnt), 5);
        for (int c = 0; c < 10; c++) begin
            step(sent < 3, mk(24'(sent + 1)), 1'b1, 1'b0);
            if (last_acc) sent++;
            if (obs_drn) got.push_back(obs_word);
        end
        chk_int("drain_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk_int("drain_order", (i < got.size()) ? int'(got[i]) : -1, i + 1);

        // Flush while full with a same-cycle accept offered.
        do_reset();
        step(1'b1, mk(24'd1), 1'b0, 1'b0);
        step(1'b1, mk(24'd2), 1'b0, 1'b0);
        chk_int("full_occupancy", int'(bus.occupancy), CAP);
        step(1'b1, mk(24'h00DEAD), 1'b0, 1'b1);
        chk_bit("flush_valid", bus.out_valid, 1'b0);
        chk_int("flush_occupancy", int'(bus.occupancy), 0);
        chk_pay("flush_data", bus.out_data, bubble());
        chk_bit("flush_in_ready", bus.in_ready, 1'b1);
        drains = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (obs_drn) drains++;
        end
        chk_int("flush_no_leak", drains, 0);

        // Stall counter saturation.
        do_reset();
        step(1'b1, mk(24'd5), 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, '0, 1'b0, 1'b0);
        chk_int("stall_saturate", int'(bus.stall_cnt), STALL_MAX);

        // Ready path relative to out_ready within a cycle.
        do_reset();
        step(1'b1, mk(24'd7), 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
        step(1'b1, mk(24'd8), 1'b0, 1'b0);
        chk_bit("skid_full_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk_bit("skid_ready_registered", bus.in_ready, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk_bit("skid_ready_back", bus.in_ready, 1'b1);
        chk_pay("skid_next_data", bus.out_data, mk(24'd8));
`else
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(24'd8);
        bus.out_ready = 1'b0;
        #1;
        chk_bit("comb_ready_low", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk_bit("comb_ready_high", bus.in_ready, 1'b1);
        step(1'b1, mk(24'd8), 1'b1, 1'b0);
        chk_bit("comb_xfer_valid", bus.out_valid, 1'b1);
        chk_pay("comb_xfer_data", bus.out_data, mk(24'd8));
`endif

        // Random traffic against the model, with one mid-run async reset.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                step(1'b1, rnd_payload(), 1'b0, 1'b0);
                do_reset();
            end
            step($urandom_range(0, 3) != 0, rnd_payload(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
